// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit
//
// Purpose:
//   One request at a time. Operands are reduced to magnitudes when the request
//   is accepted. The unit then runs one shift-add multiply step or one restoring
//   divide step per cycle for D_WIDTH cycles. The sign is restored on the way
//   into DONE, where the result is held until it is consumed or killed.
//   Divide by zero and signed overflow skip the iterations, giving latency 1.
//
// Configuration macro:
//   MULDIV_DIV_EN - compiles in the divider datapath.
//                   When undefined, ops 100-111 complete with result 0, err 1.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   request present
//   in_ready   unit idle and able to accept
//   op         RV32M funct3
//   opa, opb   operands (rs1, rs2)
//   kill       abort the operation in BUSY or DONE
//   out_valid  result present (DONE)
//   out_ready  consumer takes the result
//   result     operation result
//   err        unsupported-op flag, qualified by out_valid

module muldiv_unit #(
  parameter int D_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         op,
  input  logic [D_WIDTH-1:0] opa,
  input  logic [D_WIDTH-1:0] opb,
  input  logic               kill,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [D_WIDTH-1:0] result,
  output logic               err
);

  localparam int W  = D_WIDTH;
  localparam int CW = $clog2(W) + 1;
  localparam logic [CW-1:0] LAST = CW'(W);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_REM    = 3'b110;

`ifdef MULDIV_DIV_EN
  localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};
`endif

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state, state_nxt;

  logic [CW-1:0] cnt;
  logic [2:0]    op_q;
  // hi_q:lo_q is the running product, or the remainder and the quotient.
  // mc_q is the multiplicand, or the divisor.
  logic [W-1:0]  hi_q, lo_q, mc_q;
  logic          neg_q;
  logic          fast_q;
  logic          fast_err_q;
`ifdef MULDIV_DIV_EN
  logic          neg_rem_q;
`endif

  logic accept;
  logic finish;

  // ------------------------------------------------------------------
  // Accept-side operand conditioning
  // ------------------------------------------------------------------
  logic         a_signed, b_signed, a_neg, b_neg;
  logic [W-1:0] a_mag, b_mag;
  logic         fast_in, fast_err_in;
  logic [W-1:0] fast_res_in;

  always_comb begin
    a_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    a_neg    = a_signed & opa[W-1];
    b_neg    = b_signed & opb[W-1];
    a_mag    = a_neg ? -opa : opa;
    b_mag    = b_neg ? -opb : opb;

    fast_in     = 1'b0;
    fast_err_in = 1'b0;
    fast_res_in = '0;
`ifdef MULDIV_DIV_EN
    if (op[2]) begin
      if (opb == '0) begin
        fast_in     = 1'b1;
        fast_res_in = op[1] ? opa : '1;
      end else if (!op[0] && (opa == MIN_VAL) && (opb == '1)) begin
        fast_in     = 1'b1;
        fast_res_in = op[1] ? '0 : MIN_VAL;
      end
    end
`else
    if (op[2]) begin
      fast_in     = 1'b1;
      fast_err_in = 1'b1;
    end
`endif
  end

  // ------------------------------------------------------------------
  // One iteration step
  // ------------------------------------------------------------------
  logic [W:0]   mul_sum;
  logic [W-1:0] hi_step, lo_step;
`ifdef MULDIV_DIV_EN
  logic [W:0]   div_sh, div_diff;
`endif

  always_comb begin
    // Shift-add: the multiplier sits in lo_q and shifts out LSB first, while the
    // product grows into hi_q. The adder carry becomes the new top bit.
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mc_q} : '0);
    hi_step = mul_sum[W:1];
    lo_step = {mul_sum[0], lo_q[W-1:1]};
`ifdef MULDIV_DIV_EN
    // Restoring divide: the dividend shifts from lo_q into the remainder, and
    // quotient bits fill lo_q from the bottom. Bit W of the trial difference
    // is the borrow, because the shifted remainder is below 2*divisor.
    div_sh   = {hi_q, lo_q[W-1]};
    div_diff = div_sh - {1'b0, mc_q};
    if (op_q[2]) begin
      hi_step = div_diff[W] ? div_sh[W-1:0] : div_diff[W-1:0];
      lo_step = {lo_q[W-2:0], ~div_diff[W]};
    end
`endif
  end

  // ------------------------------------------------------------------
  // Sign correction applied on entry to DONE
  // ------------------------------------------------------------------
  logic [2*W-1:0] prod, prod_fix;
  logic [W-1:0]   fin_res;

  always_comb begin
    prod     = {hi_q, lo_q};
    prod_fix = neg_q ? -prod : prod;
    fin_res  = (op_q == OP_MUL) ? prod_fix[W-1:0] : prod_fix[2*W-1:W];
`ifdef MULDIV_DIV_EN
    if (op_q[2]) begin
      fin_res = op_q[1] ? (neg_rem_q ? -hi_q : hi_q) : (neg_q ? -lo_q : lo_q);
    end
`endif
  end

  // ------------------------------------------------------------------
  // Control FSM
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = BUSY;
      end
      BUSY: begin
        if (kill)                        state_nxt = IDLE;
        else if (fast_q || cnt == LAST)  state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (kill || out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept = in_valid && in_ready;
  assign finish = (state == BUSY) && (state_nxt == DONE);

  // ------------------------------------------------------------------
  // Datapath registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      op_q       <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      mc_q       <= '0;
      neg_q      <= 1'b0;
      fast_q     <= 1'b0;
      fast_err_q <= 1'b0;
`ifdef MULDIV_DIV_EN
      neg_rem_q  <= 1'b0;
`endif
      result     <= '0;
      err        <= 1'b0;
    end else begin
      if (accept) begin
        op_q       <= op;
        cnt        <= '0;
        hi_q       <= '0;
        neg_q      <= a_neg ^ b_neg;
        fast_q     <= fast_in;
        fast_err_q <= fast_err_in;
`ifdef MULDIV_DIV_EN
        neg_rem_q  <= a_neg;
`endif
        if (op[2]) begin
          mc_q <= b_mag;
          lo_q <= a_mag;
        end else begin
          mc_q <= a_mag;
          lo_q <= b_mag;
        end
        // The fast-path result travels in lo_q to the DONE transition.
        if (fast_in) lo_q <= fast_res_in;
      end else if ((state == BUSY) && !kill && !finish) begin
        hi_q <= hi_step;
        lo_q <= lo_step;
        cnt  <= cnt + 1'b1;
      end

      if (finish) begin
        result <= fast_q ? lo_q : fin_res;
        err    <= fast_err_q;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - scoreboard testbench for muldiv_unit
module tb_muldiv_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         kill = 1'b0;
  logic         out_ready = 1'b0;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] opa = '0;
  logic [W-1:0] opb = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] result;
  logic         err;

  muldiv_unit #(.D_WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .opa       (opa),
    .opb       (opb),
    .kill      (kill),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .err       (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] res;
    logic         err;
    int           due;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   passed = 0;
  bit   first_pending = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Reference model: plain 64-bit arithmetic on the RV32M definitions.
  function automatic void model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] r, output logic e, output int lat);
    longint      sa, sbv, ua, ub;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    ua  = longint'({32'd0, a});
    ub  = longint'({32'd0, b});
    e   = 1'b0;
    lat = W + 1;
    p   = '0;
    r   = '0;
    case (o)
      3'd0: begin p = sa * sbv; r = p[31:0]; end
      3'd1: begin p = sa * sbv; r = p[63:32]; end
      3'd2: begin p = sa * ub;  r = p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; r = p[63:32]; end
      default: begin
`ifdef MULDIV_DIV_EN
        if (b == 32'd0) begin
          r   = o[1] ? a : 32'hFFFF_FFFF;
          lat = 1;
        end else if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          r   = o[1] ? 32'd0 : 32'h8000_0000;
          lat = 1;
        end else begin
          case (o)
            3'd4:    p = sa / sbv;
            3'd5:    p = ua / ub;
            3'd6:    p = sa % sbv;
            default: p = ua % ub;
          endcase
          r = p[31:0];
        end
`else
        r   = '0;
        e   = 1'b1;
        lat = 1;
`endif
      end
    endcase
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 6))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit track, input bit kill_at_accept);
    exp_t ex;
    int   lat;
    @(negedge clk);
    in_valid = 1'b1;
    op       = o;
    opa      = a;
    opb      = b;
    kill     = kill_at_accept;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    kill     = 1'b0;
    op       = 3'($urandom);
    opa      = $urandom;
    opb      = $urandom;
    if (track) begin
      model(o, a, b, ex.res, ex.err, lat);
      ex.due = cyc + lat;
      sb.push_back(ex);
    end
  endtask

  // Wait for the scoreboard to empty.
  // Consumer back-pressure is random, and in_valid toggles as noise.
  task automatic drain(input bit rand_ready);
    int n;
    n = 0;
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() == 0 || n >= 300) break;
      out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_valid  = 1'($urandom_range(0, 1));
      op        = 3'($urandom);
      opa       = $urandom;
      opb       = $urandom;
      n++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("drain_timeout", 64'(sb.size()), 64'd0);
    sb.delete();
    first_pending = 1'b1;
  endtask

  // Monitor: compares every presented result against the scoreboard head.
  always @(negedge clk) begin
    if (out_valid) begin
      chk("valid_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        if (first_pending) begin
          chk("latency", 64'(cyc), 64'(sb[0].due));
          first_pending = 1'b0;
        end
        chk("result", 64'(result), 64'(sb[0].res));
        chk("err", 64'(err), 64'(sb[0].err));
        if (out_ready) begin
          void'(sb.pop_front());
          first_pending = 1'b1;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [2:0] o;

    // Reset values
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors
    issue(3'd0, 32'd7, 32'hFFFF_FFFD, 1, 0);                 drain(1);
    issue(3'd1, 32'h8000_0000, 32'h8000_0000, 1, 0);         drain(1);
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1);         drain(1);
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0);         drain(1);
    issue(3'd4, 32'hFFFF_FFF9, 32'd2, 1, 0);                 drain(1);
    issue(3'd6, 32'hFFFF_FFF9, 32'd2, 1, 0);                 drain(1);
    issue(3'd5, 32'd100, 32'd7, 1, 0);                       drain(1);
    issue(3'd7, 32'd100, 32'd7, 1, 0);                       drain(1);
    issue(3'd4, 32'd5, 32'd0, 1, 0);                         drain(1);
    issue(3'd6, 32'd5, 32'd0, 1, 0);                         drain(1);
    issue(3'd5, 32'd9, 32'd0, 1, 0);                         drain(1);
    issue(3'd7, 32'd9, 32'd0, 1, 0);                         drain(1);
    issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1, 0);         drain(1);
    issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1, 0);         drain(1);

    // Randomized ops
    for (int i = 0; i < 80; i++) begin
      o = 3'($urandom);
      issue(o, pick(), pick(), 1, 0);
      drain(1);
    end

    // Hold in DONE with out_ready low for 5 cycles
    issue(3'd0, 32'd12345, 32'd678, 1, 0);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("hold_reached", 64'(out_valid), 64'd1);
    repeat (5) begin
      @(negedge clk);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      chk("hold_out_valid", 64'(out_valid), 64'd1);
    end
    drain(0);

    // Kill on BUSY cycle 10
    issue(3'd3, $urandom, $urandom, 0, 0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    kill = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    chk("kill_busy_in_ready", 64'(in_ready), 64'd1);
    chk("kill_busy_out_valid", 64'(out_valid), 64'd0);
    repeat (40) @(negedge clk);
    chk("kill_busy_idle", 64'(in_ready), 64'd1);
    issue(3'd1, 32'hDEAD_BEEF, 32'h1234_5678, 1, 0);
    drain(1);

    // Kill in DONE while out_ready is low
    issue(3'd2, 32'h8765_4321, 32'h0F0F_0F0F, 1, 0);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("kill_done_reached", 64'(out_valid), 64'd1);
    @(posedge clk);
    #2;
    kill = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    chk("kill_done_out_valid", 64'(out_valid), 64'd0);
    chk("kill_done_in_ready", 64'(in_ready), 64'd1);
    sb.delete();
    first_pending = 1'b1;
    issue(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0);
    drain(1);

    // Asynchronous reset mid-BUSY, away from any clock edge
    issue(3'd1, 32'hCAFE_F00D, 32'h0BAD_CAFE, 0, 0);
    repeat (7) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_result", 64'(result), 64'd0);
    chk("arst_err", 64'(err), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (45) @(negedge clk);
    chk("post_reset_no_valid", 64'(out_valid), 64'd0);
    chk("post_reset_in_ready", 64'(in_ready), 64'd1);

    // DIVU after reset (result depends on whether the divider is built)
    issue(3'd5, 32'd100, 32'd7, 1, 0);
    drain(1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
